// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - dmem_access codes, FSM encoding and code classifiers
package mem_access_pkg;

  localparam logic [3:0] LD_BU    = 4'b0001;
  localparam logic [3:0] LD_B     = 4'b0010;
  localparam logic [3:0] LD_HU    = 4'b0100;
  localparam logic [3:0] LD_H     = 4'b1000;
  localparam logic [3:0] LD_W     = 4'b0110;
  localparam logic [3:0] ST_B     = 4'b0011;
  localparam logic [3:0] ST_H     = 4'b1100;
  localparam logic [3:0] ST_W     = 4'b1001;
  localparam logic [3:0] ACC_NONE = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic is_load(input logic [3:0] t);
    case (t)
      LD_BU, LD_B, LD_HU, LD_H, LD_W: is_load = 1'b1;
      default:                        is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] t);
    case (t)
      ST_B, ST_H, ST_W: is_store = 1'b1;
      default:          is_store = 1'b0;
    endcase
  endfunction

  // ACC_NONE is a legal code but never starts an access.
  function automatic logic is_legal(input logic [3:0] t);
    is_legal = is_load(t) || is_store(t) || (t == ACC_NONE);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] t, input logic [1:0] lo);
    case (t)
      LD_H, LD_HU, ST_H: is_misaligned = lo[0];
      LD_W, ST_W:        is_misaligned = (lo != 2'b00);
      default:           is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store strobe/lane replication and load lane extraction/extension
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  acc_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    case (acc_type_i)
      ST_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      ST_H: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      ST_W: begin
        wstrb_o = 4'b1111;
        wdata_o = st_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  end

  always_comb begin
    ld_data_o = 32'h0;
    case (acc_type_i)
      LD_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data_o = {24'h0, ld_byte};
      LD_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data_o = {16'h0, ld_half};
      LD_W:    ld_data_o = ld_word_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access sequencer (req/ack, stall, timeout)
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses complete with resp_err, unissued.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  input  logic [3:0]        acc_type,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  output logic              mem_stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              misaligned;
  logic              busy;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ld_data;

  assign accept = (state_q == S_IDLE) && acc_valid && is_legal(acc_type) && (acc_type != ACC_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = accept && is_misaligned(acc_type, acc_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_align (
    .acc_type_i (type_q),
    .addr_lo_i  (addr_q[1:0]),
    .st_data_i  (wdata_q),
    .ld_word_i  (mem_rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d  = acc_type;
          addr_d  = acc_addr;
          wdata_d = acc_wdata;
          cnt_d   = 8'd0;
          rdata_d = 32'h0;
          err_d   = misaligned;
          state_d = misaligned ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          rdata_d = is_load(type_q) ? al_ld_data : 32'h0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
          // Counting this cycle reaches MAX_WAIT: abandon the access.
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      type_q  <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == S_BUSY);
  assign mem_stall  = accept || busy;
  assign mem_req    = busy;
  assign mem_we     = busy && is_store(type_q);
  assign mem_wstrb  = mem_we ? al_wstrb : 4'b0000;
  assign mem_wdata  = mem_we ? al_wdata : 32'h0;
  assign mem_addr   = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_valid;
  logic [3:0]  acc_type;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        mem_stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MAX_WAIT(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_valid  (acc_valid),
    .acc_type   (acc_type),
    .acc_addr   (acc_addr),
    .acc_wdata  (acc_wdata),
    .mem_stall  (mem_stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input string tag, input logic [3:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd);
    acc_valid = 1'b1; acc_type = t; acc_addr = a; acc_wdata = wd;
    #1;
    check({tag, ".stall_accept"}, mem_stall, 1);
    check({tag, ".req_accept"}, mem_req, 0);
    tick();
    for (int i = 0; i <= ack_dly; i++) begin
      check({tag, ".req"}, mem_req, 1);
      check({tag, ".stall_busy"}, mem_stall, 1);
      check({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
      check({tag, ".we"}, mem_we, (exp_strb != 4'b0000));
      check({tag, ".wstrb"}, mem_wstrb, exp_strb);
      check({tag, ".wdata"}, mem_wdata, exp_wd);
      if (i == ack_dly) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
      tick();
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    end
    check({tag, ".resp_valid"}, resp_valid, 1);
    check({tag, ".resp_rdata"}, resp_rdata, exp_rd);
    check({tag, ".resp_err"}, resp_err, 0);
    check({tag, ".stall_resp"}, mem_stall, 0);
    check({tag, ".req_resp"}, mem_req, 0);
    acc_valid = 1'b0; acc_type = 4'b1111;
    tick();
    check({tag, ".resp_done"}, resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; acc_valid = 1'b0; acc_type = 4'b1111; acc_addr = 32'h0;
    acc_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    check("rst.stall", mem_stall, 0);
    check("rst.req", mem_req, 0);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_rdata", resp_rdata, 0);
    check("rst.addr", mem_addr, 0);
    check("rst.wstrb", mem_wstrb, 0);
    rst = 1'b0;
    tick();

    do_access("ld_b",  4'b0010, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 4'b0000, 32'h0, 32'hFFFF_FF80);
    do_access("ld_hu", 4'b0100, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1, 4'b0000, 32'h0, 32'h0000_8001);
    do_access("st_b",  4'b0011, 32'h0000_3001, 32'h0000_00AB, 32'h0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    do_access("st_h",  4'b1100, 32'h0000_3002, 32'h0000_BEEF, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_access("ld_h",  4'b1000, 32'h0000_0000, 32'h0, 32'h1234_8765, 0, 4'b0000, 32'h0, 32'hFFFF_8765);
    do_access("ld_bu", 4'b0001, 32'h0000_0002, 32'h0, 32'h00A5_0000, 0, 4'b0000, 32'h0, 32'h0000_00A5);
    do_access("st_w",  4'b1001, 32'h0000_0010, 32'h1234_5678, 32'h0, 2, 4'b1111, 32'h1234_5678, 32'h0);

    // Timeout: ack withheld, MAX_WAIT=4.
    acc_valid = 1'b1; acc_type = 4'b1001; acc_addr = 32'h0000_5000; acc_wdata = 32'hCAFE_F00D;
    #1;
    check("to.stall_accept", mem_stall, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to.req", mem_req, 1);
      check("to.wstrb", mem_wstrb, 4'b1111);
      tick();
    end
    check("to.req_dropped", mem_req, 0);
    check("to.resp_valid", resp_valid, 1);
    check("to.resp_err", resp_err, 1);
    check("to.resp_rdata", resp_rdata, 0);
    acc_valid = 1'b0; acc_type = 4'b1111;
    tick();
    check("to.idle", resp_valid, 0);

    // Illegal / no-access codes are never accepted.
    acc_valid = 1'b1; acc_type = 4'b1111; acc_addr = 32'h100;
    #1;
    check("none.stall", mem_stall, 0);
    tick();
    check("none.req", mem_req, 0);
    acc_type = 4'b0101;
    #1;
    check("ill.stall", mem_stall, 0);
    tick();
    check("ill.req", mem_req, 0);
    check("ill.resp", resp_valid, 0);

    // Ack outside BUSY is ignored.
    acc_valid = 1'b0; mem_ack = 1'b1;
    tick();
    check("stray_ack.resp", resp_valid, 0);
    mem_ack = 1'b0;

    // Reset while BUSY.
    acc_valid = 1'b1; acc_type = 4'b0110; acc_addr = 32'h0000_6000;
    tick();
    check("rstb.req_before", mem_req, 1);
    acc_valid = 1'b0; acc_type = 4'b1111; rst = 1'b1;
    tick();
    check("rstb.req", mem_req, 0);
    check("rstb.resp", resp_valid, 0);
    rst = 1'b0;
    tick();
    check("rstb.resp_after", resp_valid, 0);

`ifdef MEM_ALIGN_CHECK_EN
    acc_valid = 1'b1; acc_type = 4'b0110; acc_addr = 32'h0000_4002;
    #1;
    check("mis.stall", mem_stall, 1);
    tick();
    check("mis.req", mem_req, 0);
    check("mis.resp_valid", resp_valid, 1);
    check("mis.resp_err", resp_err, 1);
    check("mis.resp_rdata", resp_rdata, 0);
    acc_valid = 1'b0; acc_type = 4'b1111;
    tick();
    check("mis.idle", resp_valid, 0);
`else
    do_access("ld_w_trunc", 4'b0110, 32'h0000_4002, 32'h0, 32'hCAFE_BABE, 0, 4'b0000, 32'h0, 32'hCAFE_BABE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
